rb_fifo_gen: RTL and testbench



---
 rtl/rb_fifo_gen.sv | 112 +++++++++++
 tb/tb_rb_fifo_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rb_fifo_gen.sv
// rtl/rb_fifo_gen.sv - parametrised ring-buffer FIFO with simultaneous push/pop, flush, watermarks and sticky error flags
module rb_fifo_gen #(
    parameter int MSBD     = 3,
    parameter int DEPTH    = 16,
    parameter int MSBA     = 3,
    parameter int MSBC     = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [MSBD:0]   dataIn,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic            clearErr,
    output logic [MSBD:0]   dataOut,
    output logic            full,
    output logic            empty,
    output logic            almostFull,
    output logic            almostEmpty,
    output logic [MSBC:0]   count,
    output logic            overflow,
    output logic            underflow
);

    localparam logic [MSBC:0] C_DEPTH  = (MSBC+1)'(DEPTH);
    localparam logic [MSBC:0] C_AF     = (MSBC+1)'(AF_LEVEL);
    localparam logic [MSBC:0] C_AE     = (MSBC+1)'(AE_LEVEL);
    localparam logic [MSBC:0] C_ONE_C  = (MSBC+1)'(1);
    localparam logic [MSBA:0] C_LAST_A = (MSBA+1)'(DEPTH-1);
    localparam logic [MSBA:0] C_ONE_A  = (MSBA+1)'(1);

    logic [MSBD:0] r_mem [0:DEPTH-1];
    logic [MSBA:0] r_head;
    logic [MSBA:0] r_tail;
    logic [MSBC:0] r_count;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_push_do;
    logic          w_ovf_set;
    logic          w_udf_set;
    logic [MSBA:0] w_head_nxt;
    logic [MSBA:0] w_tail_nxt;

    // Explicit wrap compare so non-power-of-2 depths never rely on bit overflow
    function automatic logic [MSBA:0] adv(input logic [MSBA:0] p);
        return (p == C_LAST_A) ? '0 : p + C_ONE_A;
    endfunction

    always_comb begin
        w_full     = (r_count == C_DEPTH);
        w_empty    = (r_count == '0);
        w_push_ok  = push & (~w_full | (pop & ~w_empty));
        w_pop_ok   = pop & ~w_empty;
        w_push_do  = w_push_ok & ~flush & ~reset;
        w_ovf_set  = push & ~w_push_ok & ~flush;
        w_udf_set  = pop & ~w_pop_ok & ~flush;
        w_head_nxt = adv(r_head);
        w_tail_nxt = adv(r_tail);
    end

    always_ff @(posedge clock) begin
        if (w_push_do) begin
            r_mem[r_head] <= dataIn;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push_ok) r_head <= w_head_nxt;
                if (w_pop_ok)  r_tail <= w_tail_nxt;
                case ({w_push_ok, w_pop_ok})
                    2'b10:   r_count <= r_count + C_ONE_C;
                    2'b01:   r_count <= r_count - C_ONE_C;
                    default: r_count <= r_count;
                endcase
            end
            // A new error event outranks a clear requested in the same cycle
            if (w_ovf_set)     r_overflow <= 1'b1;
            else if (clearErr) r_overflow <= 1'b0;
            if (w_udf_set)     r_underflow <= 1'b1;
            else if (clearErr) r_underflow <= 1'b0;
        end
    end

    assign dataOut     = r_mem[r_tail];
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostFull  = (r_count >= C_AF);
    assign almostEmpty = (r_count <= C_AE);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_rb_fifo_gen.sv
// tb/tb_rb_fifo_gen.sv - self-checking bench for rb_fifo_gen against a queue-based reference model
module tb_rb_fifo_gen;

    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] dataIn;
    logic       push;
    logic       pop;
    logic       flush;
    logic       clearErr;
    logic [3:0] dataOut;
    logic       full;
    logic       empty;
    logic       almostFull;
    logic       almostEmpty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    rb_fifo_gen #(
        .MSBD(3), .DEPTH(DEPTH), .MSBA(2), .MSBC(2), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clock(clock), .reset(reset), .dataIn(dataIn), .push(push), .pop(pop),
        .flush(flush), .clearErr(clearErr), .dataOut(dataOut), .full(full),
        .empty(empty), .almostFull(almostFull), .almostEmpty(almostEmpty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    logic [3:0] q[$];
    logic       m_ovf;
    logic       m_udf;
    int         n_pass;
    int         n_total;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference behaviour expressed as queue operations on the pre-edge state
    task automatic model(input logic r, input logic p, input logic po, input logic f,
                         input logic c, input logic [3:0] d);
        bit is_full, is_empty, pok, pp;
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (f) begin
            q.delete();
            if (c) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        end else begin
            is_full  = (q.size() == DEPTH);
            is_empty = (q.size() == 0);
            pp  = po && !is_empty;
            pok = p && (!is_full || pp);
            if (p && !pok)     m_ovf = 1'b1;
            else if (c)        m_ovf = 1'b0;
            if (po && !pp)     m_udf = 1'b1;
            else if (c)        m_udf = 1'b0;
            if (pp)  void'(q.pop_front());
            if (pok) q.push_back(d);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ".count"}, 8'(count), 8'(n));
        check({tag, ".full"}, 8'(full), 8'(n == DEPTH));
        check({tag, ".empty"}, 8'(empty), 8'(n == 0));
        check({tag, ".af"}, 8'(almostFull), 8'(n >= AF));
        check({tag, ".ae"}, 8'(almostEmpty), 8'(n <= AE));
        check({tag, ".ovf"}, 8'(overflow), 8'(m_ovf));
        check({tag, ".udf"}, 8'(underflow), 8'(m_udf));
        check({tag, ".excl"}, 8'(full & empty), 8'(0));
        if (n != 0) check({tag, ".dout"}, 8'(dataOut), 8'(q[0]));
    endtask

    task automatic cyc(input string tag, input logic r, input logic p, input logic po,
                       input logic f, input logic c, input logic [3:0] d);
        reset = r; push = p; pop = po; flush = f; clearErr = c; dataIn = d;
        @(posedge clock);
        model(r, p, po, f, c, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        m_ovf = 1'b0; m_udf = 1'b0;
        reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clearErr = 1'b0; dataIn = '0;

        cyc("reset", 1, 0, 0, 0, 0, 4'h0);
        check("rst.count", 8'(count), 8'd0);
        check("rst.empty", 8'(empty), 8'd1);
        check("rst.full", 8'(full), 8'd0);
        check("rst.ae", 8'(almostEmpty), 8'd1);
        check("rst.af", 8'(almostFull), 8'd0);
        check("rst.flags", 8'({overflow, underflow}), 8'd0);

        // fill with A..E
        for (int i = 0; i < 5; i++) cyc("fill", 0, 1, 0, 0, 0, 4'(4'hA + i));
        check("fill.full", 8'(full), 8'd1);
        check("fill.head", 8'(dataOut), 8'hA);

        cyc("ovf", 0, 1, 0, 0, 0, 4'hF);
        check("ovf.set", 8'(overflow), 8'd1);
        check("ovf.count", 8'(count), 8'd5);
        for (int i = 0; i < 5; i++) begin
            check("drain.order", 8'(dataOut), 8'(4'hA + i));
            cyc("drain", 0, 0, 1, 0, 0, 4'h0);
        end
        check("drain.ovf_kept", 8'(overflow), 8'd1);
        cyc("clr", 0, 0, 0, 0, 1, 4'h0);
        check("clr.ovf", 8'(overflow), 8'd0);

        // wrap: hold count at 2 with simultaneous push/pop
        cyc("wrap.pre", 0, 1, 0, 0, 0, 4'h1);
        cyc("wrap.pre", 0, 1, 0, 0, 0, 4'h2);
        for (int i = 0; i < 12; i++) cyc("wrap", 0, 1, 1, 0, 0, 4'(i + 3));
        check("wrap.count", 8'(count), 8'd2);

        // full with simultaneous push/pop
        for (int i = 0; i < 3; i++) cyc("refill", 0, 1, 0, 0, 0, 4'(8 + i));
        cyc("fullpp", 0, 1, 1, 0, 0, 4'h3);
        check("fullpp.count", 8'(count), 8'd5);
        check("fullpp.ovf", 8'(overflow), 8'd0);

        // empty with simultaneous push/pop
        cyc("flush0", 0, 0, 0, 1, 0, 4'h0);
        cyc("emptypp", 0, 1, 1, 0, 0, 4'h7);
        check("emptypp.dout", 8'(dataOut), 8'h7);
        check("emptypp.udf", 8'(underflow), 8'd1);
        cyc("pop1", 0, 0, 1, 0, 0, 4'h0);
        cyc("udf_vs_clr", 0, 0, 1, 0, 1, 4'h0);
        check("udf_sticky", 8'(underflow), 8'd1);

        // flush with push, then reset mid-stream
        for (int i = 0; i < 3; i++) cyc("pre_flush", 0, 1, 0, 0, 0, 4'(i + 1));
        cyc("flush_push", 0, 1, 0, 1, 0, 4'h9);
        check("flush.empty", 8'(empty), 8'd1);
        check("flush.udf_kept", 8'(underflow), 8'd1);
        cyc("pre_rst", 0, 1, 0, 0, 0, 4'h4);
        cyc("pre_rst", 0, 1, 0, 0, 0, 4'h5);
        cyc("mid_rst", 1, 1, 0, 0, 0, 4'h6);
        check("mid_rst.count", 8'(count), 8'd0);
        check("mid_rst.flags", 8'({overflow, underflow}), 8'd0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc("rand",
                ($urandom_range(0, 63) == 0),
                ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 7) == 0),
                4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
